sa_seq_ctrl: RTL and testbench



---
 rtl/sa_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_sa_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_seq_ctrl.sv
// sa_seq_ctrl: layer sequencer for the CNN systolic array.
// Each layer runs in three phases:
//   PREFETCH - reads the weights in reverse address order and shifts them into the PEs.
//   FEED     - streams im2col pixels in raster order, with a per-row skew register.
//   DRAIN    - waits until every output beat is counted and the skew register is empty.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   i_start             starts a layer; only sampled in IDLE
//   i_stall             buffer backpressure; freezes sequencing
//   i_of_valid          one output beat from the array this cycle
//   o_w_rd_en/o_w_addr  weight buffer read enable and address
//   o_w_load            PE weight shift-in enable (read enable delayed by one cycle)
//   o_if_rd_en/o_if_addr feature buffer read enable and pixel index
//   o_skew_valid        per-array-row valid (skew register)
//   o_of_cnt            output beats received, saturating at the layer total
//   o_busy, o_done      busy level and one-cycle completion pulse
//   o_err               drain watchdog error
//
// Optional feature: define SA_SEQ_CTRL_TIMEOUT_EN to enable the drain watchdog.
// Without it, DRAIN waits indefinitely and o_err is tied low.
module sa_seq_ctrl #(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned HEIGHT  = 128,
    parameter int unsigned PORT    = 27,
    parameter int unsigned NUM_COL = 3,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_start,
    input  logic                                      i_stall,
    input  logic                                      i_of_valid,
    output logic                                      o_w_rd_en,
    output logic [$clog2(PORT*NUM_COL)-1:0]           o_w_addr,
    output logic                                      o_w_load,
    output logic                                      o_if_rd_en,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]           o_if_addr,
    output logic [PORT-1:0]                           o_skew_valid,
    output logic [$clog2(WIDTH*HEIGHT*NUM_COL+1)-1:0] o_of_cnt,
    output logic                                      o_busy,
    output logic                                      o_done,
    output logic                                      o_err
);

    localparam int unsigned W_LEN = PORT * NUM_COL;
    localparam int unsigned P_LEN = WIDTH * HEIGHT;
    localparam int unsigned O_LEN = P_LEN * NUM_COL;
    localparam int unsigned WA_W  = $clog2(W_LEN);
    localparam int unsigned PA_W  = $clog2(P_LEN);
    localparam int unsigned OC_W  = $clog2(O_LEN + 1);

    // Address ports need at least one bit, and the watchdog needs a nonzero limit.
    if (W_LEN < 2 || P_LEN < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("sa_seq_ctrl: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFETCH,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    logic            w_load_q;   // weight read issued on the last unstalled cycle
    logic [PORT-1:0] sr;         // skew register, shifts only on unstalled cycles
    logic            cnt_en;

`ifdef SA_SEQ_CTRL_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic            err_q;
    logic [WD_W-1:0] wd_cnt;     // consecutive silent DRAIN cycles
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    // Stall gates the strobes in the same cycle. The underlying registers stay
    // frozen, so a strobe hidden by a stall is presented again after release.
    assign o_w_rd_en    = (state == S_PREFETCH) && !i_stall;
    assign o_if_rd_en   = (state == S_FEED) && !i_stall;
    assign o_w_load     = w_load_q && !i_stall;
    assign o_skew_valid = sr & {PORT{!i_stall}};

    // Output beats are counted in FEED and DRAIN, including stalled cycles.
    assign cnt_en = ((state == S_FEED) || (state == S_DRAIN)) && i_of_valid &&
                    (o_of_cnt != OC_W'(O_LEN));

    // Sequencer state, address counters, skew register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            o_w_addr  <= '0;
            o_if_addr <= '0;
            o_of_cnt  <= '0;
            w_load_q  <= 1'b0;
            sr        <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
`ifdef SA_SEQ_CTRL_TIMEOUT_EN
            err_q     <= 1'b0;
            wd_cnt    <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            if (cnt_en) begin
                o_of_cnt <= o_of_cnt + OC_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state    <= S_PREFETCH;
                        o_busy   <= 1'b1;
                        o_w_addr <= WA_W'(W_LEN - 1);
                        o_of_cnt <= '0;
`ifdef SA_SEQ_CTRL_TIMEOUT_EN
                        err_q    <= 1'b0;
                        wd_cnt   <= '0;
`endif
                    end
                end

                // Weights go out last-first so the first one read ends up deepest in the PE chain.
                S_PREFETCH: begin
                    if (!i_stall) begin
                        w_load_q <= 1'b1;
                        if (o_w_addr == '0) begin
                            state     <= S_FEED;
                            o_if_addr <= '0;
                        end else begin
                            o_w_addr <= o_w_addr - WA_W'(1);
                        end
                    end
                end

                S_FEED: begin
                    if (!i_stall) begin
                        w_load_q <= 1'b0;
                        sr       <= PORT'({sr, 1'b1});
                        if (o_if_addr == PA_W'(P_LEN - 1)) begin
                            state     <= S_DRAIN;
                            o_if_addr <= '0;
`ifdef SA_SEQ_CTRL_TIMEOUT_EN
                            wd_cnt    <= '0;
`endif
                        end else begin
                            o_if_addr <= o_if_addr + PA_W'(1);
                        end
                    end
                end

                S_DRAIN: begin
`ifdef SA_SEQ_CTRL_TIMEOUT_EN
                    if (i_of_valid) begin
                        wd_cnt <= '0;
                    end
`endif
                    if (!i_stall) begin
                        sr <= PORT'({sr, 1'b0});
                        if ((o_of_cnt == OC_W'(O_LEN)) && (sr == '0)) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end
`ifdef SA_SEQ_CTRL_TIMEOUT_EN
                        else if (!i_of_valid) begin
                            if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                                state  <= S_DONE;
                                o_done <= 1'b1;
                                err_q  <= 1'b1;
                                sr     <= '0;
                            end else begin
                                wd_cnt <= wd_cnt + WD_W'(1);
                            end
                        end
`endif
                    end
                end

                S_DONE: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end

                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Bench for sa_seq_ctrl. A reference model tracks the layer as a count of
// unstalled cycles since start and derives every expected output from that count.
module tb_sa_seq_ctrl;

    localparam int WIDTH   = 4;
    localparam int HEIGHT  = 2;
    localparam int PORT    = 3;
    localparam int NUM_COL = 2;
    localparam int TIMEOUT = 8;
    localparam int W_LEN   = PORT * NUM_COL;
    localparam int P_LEN   = WIDTH * HEIGHT;
    localparam int O_LEN   = P_LEN * NUM_COL;
    localparam int WA_W    = $clog2(W_LEN);
    localparam int PA_W    = $clog2(P_LEN);
    localparam int OC_W    = $clog2(O_LEN + 1);

    logic            clk;
    logic            rst;
    logic            i_start;
    logic            i_stall;
    logic            i_of_valid;
    logic            o_w_rd_en;
    logic [WA_W-1:0] o_w_addr;
    logic            o_w_load;
    logic            o_if_rd_en;
    logic [PA_W-1:0] o_if_addr;
    logic [PORT-1:0] o_skew_valid;
    logic [OC_W-1:0] o_of_cnt;
    logic            o_busy;
    logic            o_done;
    logic            o_err;

    sa_seq_ctrl #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .PORT   (PORT),
        .NUM_COL(NUM_COL),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_stall     (i_stall),
        .i_of_valid  (i_of_valid),
        .o_w_rd_en   (o_w_rd_en),
        .o_w_addr    (o_w_addr),
        .o_w_load    (o_w_load),
        .o_if_rd_en  (o_if_rd_en),
        .o_if_addr   (o_if_addr),
        .o_skew_valid(o_skew_valid),
        .o_of_cnt    (o_of_cnt),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    int dut_dones;

    // Reference model: m_u = unstalled cycles completed since the start was accepted.
    bit m_active;
    bit m_done_cyc;
    bit m_err;
    int m_u;
    int m_cnt;
    int m_silent;
    bit e_top;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, compare all outputs against the model, then advance the model.
    task automatic cycle(input bit start, input bit stall, input bit ofv, input bit rs);
        logic [PORT-1:0] e_skew;
        bit run;
        bit in_fd;
        bit in_drain;
        bit nd;
        @(negedge clk);
        rst        = rs;
        i_start    = start;
        i_stall    = stall;
        i_of_valid = ofv;
        #1;
        run    = m_active && !m_done_cyc;
        e_skew = '0;
        if (run && !stall) begin
            for (int j = 0; j < PORT; j++) begin
                if (m_u >= W_LEN + j + 1 && m_u <= W_LEN + j + P_LEN) e_skew[j] = 1'b1;
            end
        end
        e_top = e_skew[PORT-1];
        check("w_rd_en", 64'(o_w_rd_en), 64'(run && !stall && m_u < W_LEN));
        check("w_addr", 64'(o_w_addr), (run && m_u < W_LEN) ? 64'(W_LEN - 1 - m_u) : 64'd0);
        check("w_load", 64'(o_w_load), 64'(run && !stall && m_u >= 1 && m_u <= W_LEN));
        check("if_rd_en", 64'(o_if_rd_en),
              64'(run && !stall && m_u >= W_LEN && m_u < W_LEN + P_LEN));
        check("if_addr", 64'(o_if_addr),
              (run && m_u >= W_LEN && m_u < W_LEN + P_LEN) ? 64'(m_u - W_LEN) : 64'd0);
        check("skew_valid", 64'(o_skew_valid), 64'(e_skew));
        check("of_cnt", 64'(o_of_cnt), 64'(m_cnt));
        check("busy", 64'(o_busy), 64'(m_active));
        check("done", 64'(o_done), 64'(m_done_cyc));
        check("err", 64'(o_err), 64'(m_err));
        if (o_done === 1'b1) dut_dones++;

        if (rs) begin
            m_active   = 1'b0;
            m_done_cyc = 1'b0;
            m_cnt      = 0;
            m_err      = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_u      = 0;
                m_cnt    = 0;
                m_err    = 1'b0;
                m_silent = 0;
            end
        end else if (m_done_cyc) begin
            m_active   = 1'b0;
            m_done_cyc = 1'b0;
        end else begin
            in_fd    = (m_u >= W_LEN);
            in_drain = (m_u >= W_LEN + P_LEN);
            nd       = in_drain && !stall && (m_cnt == O_LEN) && (m_u >= W_LEN + P_LEN + PORT);
`ifdef SA_SEQ_CTRL_TIMEOUT_EN
            if (in_drain) begin
                if (ofv) m_silent = 0;
                else if (!stall) begin
                    m_silent++;
                    if (!nd && m_silent >= TIMEOUT) begin
                        nd    = 1'b1;
                        m_err = 1'b1;
                    end
                end
            end
`endif
            if (in_fd && ofv && m_cnt < O_LEN) m_cnt++;
            if (!stall) m_u++;
            if (nd) m_done_cyc = 1'b1;
        end
    endtask

    // mode 0: array returns NUM_COL beats per valid top row, with random gaps.
    // mode 1: a beat every cycle from the first FEED cycle on.
    task automatic run_layer(input int mode, input int stall_at, input int stall_len,
                             input int stall_rate, input int beat_cap, input int rst_at,
                             input int exp_dones, input int exp_cnt);
        int pending;
        int sent;
        int left;
        int dones0;
        bit st;
        bit ofv;
        bit rs;
        bit stt;
        bit rst_done;
        pending  = 0;
        sent     = 0;
        left     = stall_len;
        rst_done = 1'b0;
        dones0   = dut_dones;
        cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        for (int c = 0; c < 400 && m_active; c++) begin
            st  = 1'b0;
            ofv = 1'b0;
            rs  = 1'b0;
            if (stall_at >= 0 && m_u == stall_at && left > 0 && !m_done_cyc) begin
                st = 1'b1;
                left--;
            end else if (stall_rate > 0 && $urandom_range(0, stall_rate - 1) == 0) begin
                st = 1'b1;
            end
            if (mode == 0) begin
                if (pending > 0 && sent < beat_cap && $urandom_range(0, 3) != 0) begin
                    ofv = 1'b1;
                    pending--;
                    sent++;
                end
            end else if (m_u >= W_LEN && sent < beat_cap) begin
                ofv = 1'b1;
                sent++;
            end
            if (!ofv && m_u < W_LEN && $urandom_range(0, 5) == 0) ofv = 1'b1;
            if (rst_at >= 0 && !rst_done && m_u == rst_at) begin
                rs       = 1'b1;
                rst_done = 1'b1;
            end
            stt = ($urandom_range(0, 7) == 0) || (m_u == W_LEN + 2);
            cycle(stt, st, ofv, rs);
            if (e_top) pending += NUM_COL;
        end
        check("done_pulses", 64'(dut_dones - dones0), 64'(exp_dones));
        check("final_cnt", 64'(o_of_cnt), 64'(exp_cnt));
        repeat (2) cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        dut_dones  = 0;
        m_active   = 1'b0;
        m_done_cyc = 1'b0;
        m_err      = 1'b0;
        m_u        = 0;
        m_cnt      = 0;
        m_silent   = 0;
        e_top      = 1'b0;
        rst        = 1'b1;
        i_start    = 1'b0;
        i_stall    = 1'b0;
        i_of_valid = 1'b0;
        repeat (3) @(negedge clk);

        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        run_layer(0, -1, 0, 0, O_LEN, -1, 1, O_LEN);            // nominal
        run_layer(0, W_LEN + 4, 3, 0, O_LEN, -1, 1, O_LEN);     // 3-cycle stall at pixel 4
        run_layer(0, -1, 0, 0, O_LEN, W_LEN - 3, 0, 0);         // reset at weight addr 2
        run_layer(0, -1, 0, 0, O_LEN, -1, 1, O_LEN);            // replay after reset
        run_layer(1, W_LEN + 1, 10, 0, O_LEN + 4, -1, 1, O_LEN); // beats flood during FEED
        for (int k = 0; k < 6; k++) begin
            run_layer(0, -1, 0, 4, O_LEN, -1, 1, O_LEN);        // random stalls
        end
`ifdef SA_SEQ_CTRL_TIMEOUT_EN
        run_layer(0, -1, 0, 0, 10, -1, 1, 10);                  // watchdog expiry
        check("err_sticky", 64'(o_err), 64'd1);
        run_layer(0, -1, 0, 0, O_LEN, -1, 1, O_LEN);            // start clears err
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
